// File: rtl/dac_serial_ctrl.sv
// Multi-channel serial DAC frame controller: latches a batch of per-channel
// header/value words and shifts one {header, value} frame per enabled channel.
module dac_serial_ctrl #(
    parameter int HDR_W   = 8,
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       start_ready,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [NUM_CH*HDR_W-1:0]    header,
    input  logic [NUM_CH*DATA_W-1:0]   value,
    output logic                       busy,
    output logic [CH_W-1:0]            ch_idx,
    output logic                       frame_done,
    output logic                       all_done,
    output logic                       sync,
    output logic                       sclk,
    output logic                       din
);
    // state | meaning
    // IDLE  | waiting for a batch, start_ready high
    // SEL   | pick lowest pending channel and load its frame, or finish batch
    // SHIFT | serialise frame MSB first, sync low
    // GAP   | sync-high spacing before the next SEL
    typedef enum logic [1:0] {IDLE, SEL, SHIFT, GAP} state_t;

    localparam int FRAME_W = HDR_W + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int GAP_W   = $clog2(GAP_CYC + 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME_W - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    state_t                      state_q, state_d;
    logic [NUM_CH-1:0]           pend_q, pend_d;
    logic [NUM_CH*HDR_W-1:0]     hdr_q, hdr_d;
    logic [NUM_CH*DATA_W-1:0]    val_q, val_d;
    logic [FRAME_W-1:0]          shreg_q, shreg_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [GAP_W-1:0]            gap_q, gap_d;
    logic                        ready_d, busy_d, fd_d, ad_d, sync_d, sclk_d, din_d;
    logic [CH_W-1:0]             idx_d;

    logic                        sel_found;
    logic [CH_W-1:0]             sel_ch;
    logic [NUM_CH-1:0]           sel_oh;
    logic [FRAME_W-1:0]          sel_frame;

    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        sel_oh    = '0;
        sel_frame = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!sel_found && pend_q[i]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(i);
                sel_oh[i] = 1'b1;
                sel_frame = {hdr_q[i*HDR_W +: HDR_W], val_q[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        hdr_d   = hdr_q;
        val_d   = val_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        gap_d   = gap_q;
        ready_d = start_ready;
        busy_d  = busy;
        idx_d   = ch_idx;
        fd_d    = 1'b0;
        ad_d    = 1'b0;
        sync_d  = sync;
        sclk_d  = sclk;
        din_d   = din;
        case (state_q)
            IDLE: begin
                if (start && start_ready) begin
                    hdr_d   = header;
                    val_d   = value;
                    pend_d  = ch_mask;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (sel_found) begin
                    idx_d   = sel_ch;
                    pend_d  = pend_q & ~sel_oh;
                    shreg_d = {sel_frame[FRAME_W-2:0], 1'b0};
                    din_d   = sel_frame[FRAME_W-1];
                    sync_d  = 1'b0;
                    sclk_d  = 1'b1;
                    bit_d   = BIT_LOAD;
                    div_d   = DIV_LOAD;
                    state_d = SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    ad_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else if (sclk) begin
                    sclk_d = 1'b0;
                    div_d  = DIV_LOAD;
                end else if (bit_q == '0) begin
                    sync_d  = 1'b1;
                    sclk_d  = 1'b1;
                    din_d   = 1'b1;
                    fd_d    = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    // rising sclk ends the bit and presents the next one
                    sclk_d  = 1'b1;
                    din_d   = shreg_q[FRAME_W-1];
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    bit_d   = bit_q - BIT_W'(1);
                    div_d   = DIV_LOAD;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = SEL;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            hdr_q       <= '0;
            val_q       <= '0;
            shreg_q     <= '0;
            bit_q       <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            ch_idx      <= '0;
            frame_done  <= 1'b0;
            all_done    <= 1'b0;
            sync        <= 1'b1;
            sclk        <= 1'b1;
            din         <= 1'b1;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            hdr_q       <= hdr_d;
            val_q       <= val_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            start_ready <= ready_d;
            busy        <= busy_d;
            ch_idx      <= idx_d;
            frame_done  <= fd_d;
            all_done    <= ad_d;
            sync        <= sync_d;
            sclk        <= sclk_d;
            din         <= din_d;
        end
    end
endmodule

// File: tb/tb_dac_serial_ctrl.sv
// Bench for dac_serial_ctrl: a default instance and a fast 2-channel instance,
// both checked every cycle against a schedule-based model plus literal checks.
module tb_dac_serial_ctrl;
    typedef struct packed {
        logic       rdy;
        logic       busy;
        logic [1:0] idx;
        logic       fd;
        logic       ad;
        logic       sync;
        logic       sclk;
        logic       din;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_start, a_rdy, a_busy, a_fd, a_ad, a_sync, a_sclk, a_din;
    logic [3:0]  a_mask;
    logic [31:0] a_hdr;
    logic [63:0] a_val;
    logic [1:0]  a_idx;
    logic        b_rst, b_start, b_rdy, b_busy, b_fd, b_ad, b_sync, b_sclk, b_din;
    logic [1:0]  b_mask;
    logic [15:0] b_hdr;
    logic [31:0] b_val;
    logic [0:0]  b_idx;

    dac_serial_ctrl u_a (
        .clk(clk), .rst_n(a_rst), .start(a_start), .start_ready(a_rdy),
        .ch_mask(a_mask), .header(a_hdr), .value(a_val), .busy(a_busy),
        .ch_idx(a_idx), .frame_done(a_fd), .all_done(a_ad),
        .sync(a_sync), .sclk(a_sclk), .din(a_din)
    );

    dac_serial_ctrl #(.HDR_W(8), .DATA_W(16), .NUM_CH(2), .CH_W(1),
                      .CLK_DIV(1), .GAP_CYC(1)) u_b (
        .clk(clk), .rst_n(b_rst), .start(b_start), .start_ready(b_rdy),
        .ch_mask(b_mask), .header(b_hdr), .value(b_val), .busy(b_busy),
        .ch_idx(b_idx), .frame_done(b_fd), .all_done(b_ad),
        .sync(b_sync), .sclk(b_sclk), .din(b_din)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected outputs at offset n after the acceptance edge, from the frame schedule:
    // one SEL cycle, then per enabled channel a frame, a GAP run and a SEL cycle,
    // then the all_done cycle.
    function automatic exp_t batch_exp(int d, int g, int nch, logic [3:0] mask,
                                       logic [31:0] h, logic [63:0] v,
                                       logic [1:0] prev, int n);
        exp_t e;
        int chans[4];
        int ne, flen, slot, m, j, r, c;
        logic [23:0] word;
        e.rdy = 1'b0; e.busy = 1'b1; e.idx = prev; e.fd = 1'b0; e.ad = 1'b0;
        e.sync = 1'b1; e.sclk = 1'b1; e.din = 1'b1;
        ne = 0;
        for (int i = 0; i < nch; i++) if (mask[i]) begin chans[ne] = i; ne++; end
        flen = 24 * 2 * d;
        slot = flen + g + 1;
        if (n == 0) return e;
        m = n - 1; j = m / slot; r = m % slot;
        if (j < ne) begin
            c     = chans[j];
            e.idx = 2'(c);
            word  = {h[c*8 +: 8], v[c*16 +: 16]};
            if (r < flen) begin
                e.sync = 1'b0;
                e.sclk = ((r % (2*d)) < d);
                e.din  = word[23 - r/(2*d)];
            end else begin
                e.fd = (r == flen);
            end
        end else begin
            e.busy = 1'b0; e.rdy = 1'b1; e.ad = 1'b1;
            if (ne > 0) e.idx = 2'(chans[ne-1]);
        end
        return e;
    endfunction

    function automatic int batch_len(int d, int g, int nch, logic [3:0] mask);
        int ne;
        ne = 0;
        for (int i = 0; i < nch; i++) if (mask[i]) ne++;
        return 2 + ne * (48*d + g + 1);
    endfunction

    exp_t        cur[2];
    exp_t        act[2];
    bit          m_started[2];
    bit          m_act[2];
    int          m_n[2], m_len[2];
    logic [3:0]  m_mask[2];
    logic [31:0] m_h[2];
    logic [63:0] m_v[2];
    logic [1:0]  m_prev[2];
    logic        i_rst, i_st;
    logic [3:0]  i_mk;
    logic [31:0] i_h;
    logic [63:0] i_v;
    int          p_d, p_g, p_n;

    initial begin
        m_started[0] = 1'b0; m_started[1] = 1'b0;
        m_act[0] = 1'b0; m_act[1] = 1'b0;
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                i_rst = a_rst; i_st = a_start; i_mk = a_mask; i_h = a_hdr; i_v = a_val;
                p_d = 2; p_g = 2; p_n = 4;
            end else begin
                i_rst = b_rst; i_st = b_start; i_mk = {2'b00, b_mask};
                i_h = {16'h0, b_hdr}; i_v = {32'h0, b_val};
                p_d = 1; p_g = 1; p_n = 2;
            end
            if (!i_rst) begin
                m_started[d] = 1'b1;
                m_act[d]     = 1'b0;
                cur[d]       = 9'b1_0_00_0_0_1_1_1;
            end else if (m_started[d]) begin
                if (i_st && cur[d].rdy) begin
                    m_mask[d] = i_mk; m_h[d] = i_h; m_v[d] = i_v; m_prev[d] = cur[d].idx;
                    m_len[d]  = batch_len(p_d, p_g, p_n, i_mk);
                    cur[d]    = batch_exp(p_d, p_g, p_n, i_mk, i_h, i_v, cur[d].idx, 0);
                    m_n[d]    = 1;
                    m_act[d]  = 1'b1;
                end else if (m_act[d]) begin
                    cur[d] = batch_exp(p_d, p_g, p_n, m_mask[d], m_h[d], m_v[d], m_prev[d], m_n[d]);
                    m_n[d]++;
                    if (m_n[d] >= m_len[d]) m_act[d] = 1'b0;
                end else begin
                    cur[d].fd = 1'b0; cur[d].ad = 1'b0; cur[d].rdy = 1'b1; cur[d].busy = 1'b0;
                end
            end
        end
    end

    // per-DUT waveform statistics for the literal checks
    logic        prv_sync[2], prv_sclk[2], prv_ad[2];
    int          hi_run[2], lo_run[2], lo_last[2], gap_last[2];
    int          last_fall[2], fall_per[2], nbits[2];
    int          fd_cnt[2], ad_cnt[2], ba_first[2], wn[2], nfr[2];
    logic [23:0] sh[2];
    logic [23:0] wlog[2][8];
    int          ilog[2][8];

    task automatic clr(input int d);
        hi_run[d] = 0; lo_run[d] = 0; lo_last[d] = 0; gap_last[d] = 0;
        last_fall[d] = -1; fall_per[d] = 0; nbits[d] = 0;
        fd_cnt[d] = 0; ad_cnt[d] = 0; ba_first[d] = -1; wn[d] = 0; nfr[d] = 0; sh[d] = '0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            prv_sync[d] = 1'b1; prv_sclk[d] = 1'b1; prv_ad[d] = 1'b0;
            clr(d);
        end
    end

    always @(negedge clk) begin
        cyc++;
        act[0] = {a_rdy, a_busy, a_idx, a_fd, a_ad, a_sync, a_sclk, a_din};
        act[1] = {b_rdy, b_busy, 1'b0, b_idx, b_fd, b_ad, b_sync, b_sclk, b_din};
        for (int d = 0; d < 2; d++) begin
            if (m_started[d]) begin
                n_cmp++;
                if (act[d] !== cur[d]) begin
                    n_bad++;
                    $display("FAIL dut%0d cycle %0d rdy/busy/idx/fd/ad/sync/sclk/din: got %b expected %b",
                             d, cyc, act[d], cur[d]);
                end
            end
            if (prv_sync[d] && !act[d].sync) begin
                gap_last[d] = hi_run[d]; hi_run[d] = 0; lo_run[d] = 0;
                sh[d] = '0; nbits[d] = 0; last_fall[d] = -1;
                if (nfr[d] < 8) ilog[d][nfr[d]] = int'(act[d].idx);
                nfr[d]++;
            end
            if (act[d].sync) begin
                hi_run[d]++;
                if (!prv_sync[d]) lo_last[d] = lo_run[d];
            end else begin
                lo_run[d]++;
            end
            if (prv_sclk[d] && !act[d].sclk && !act[d].sync) begin
                sh[d] = {sh[d][22:0], act[d].din};
                nbits[d]++;
                if (last_fall[d] >= 0) fall_per[d] = cyc - last_fall[d];
                last_fall[d] = cyc;
            end
            if (act[d].fd) begin
                if (wn[d] < 8) wlog[d][wn[d]] = sh[d];
                wn[d]++; fd_cnt[d]++;
            end
            if (act[d].ad) ad_cnt[d]++;
            if (prv_ad[d] && ba_first[d] < 0) ba_first[d] = int'(act[d].busy);
            prv_sync[d] = act[d].sync; prv_sclk[d] = act[d].sclk; prv_ad[d] = act[d].ad;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic wait_ad(input int d, input int target, input int budget, input string name);
        int k;
        k = 0;
        while (ad_cnt[d] < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, int'(ad_cnt[d] >= target), 1);
    endtask

    task automatic pulse_a;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    int k;

    initial begin
        a_rst = 1'b0; a_start = 1'b0; a_mask = '0; a_hdr = '0; a_val = '0;
        b_rst = 1'b0; b_start = 1'b0; b_mask = '0; b_hdr = '0; b_val = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sync", int'(a_sync), 1);
        chk("reset_ready", int'(a_rdy), 1);
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single channel 0
        a_mask = 4'b0001; a_hdr = 32'h7F7F_7F16; a_val = 64'h1234_5678_9ABC_A5C3;
        clr(0);
        pulse_a();
        wait_ad(0, 1, 400, "t1_all_done_seen");
        repeat (3) @(posedge clk);
        #1;
        chk("t1_sync_low_cycles", lo_last[0], 96);
        chk("t1_word", int'(wlog[0][0]), 24'h16A5C3);
        chk("t1_frame_done_count", fd_cnt[0], 1);
        chk("t1_all_done_count", ad_cnt[0], 1);
        chk("t1_sclk_period", fall_per[0], 4);
        chk("t1_busy_after", int'(a_busy), 0);

        // channels 1 and 3, with a second start and new data mid-batch
        a_mask = 4'b1010; a_hdr = 32'h9E55_B210; a_val = 64'hF00F_5555_3C4D_0000;
        clr(0);
        pulse_a();
        repeat (60) @(posedge clk);
        #1;
        a_start = 1'b1; a_hdr = 32'hFFFF_FFFF; a_val = '0; a_mask = 4'b1111;
        chk("t2_ready_while_busy", int'(a_rdy), 0);
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_ad(0, 1, 600, "t2_all_done_seen");
        repeat (20) @(posedge clk);
        #1;
        chk("t2_frames", wn[0], 2);
        chk("t2_word0", int'(wlog[0][0]), 24'hB23C4D);
        chk("t2_word1", int'(wlog[0][1]), 24'h9EF00F);
        chk("t2_idx0", ilog[0][0], 1);
        chk("t2_idx1", ilog[0][1], 3);
        chk("t2_gap_high_cycles", gap_last[0], 3);
        chk("t2_all_done_count", ad_cnt[0], 1);
        chk("t2_no_second_batch", int'(a_busy), 0);

        // empty mask
        a_mask = 4'b0000;
        clr(0);
        pulse_a();
        k = 0;
        while (k < 10 && !a_ad) begin @(negedge clk); #1; k++; end
        chk("t3_all_done_latency", k, 2);
        @(negedge clk); #1;
        chk("t3_ready_again", int'(a_rdy), 1);
        chk("t3_no_frames", nfr[0], 0);

        // reset during bit 10, then a fresh frame
        a_mask = 4'b0001; a_hdr = 32'h0000_0016; a_val = 64'h0000_0000_0000_A5C3;
        clr(0);
        pulse_a();
        k = 0;
        while (k < 200 && nbits[0] < 10) begin @(negedge clk); #1; k++; end
        chk("t4_reached_bit10", nbits[0], 10);
        a_rst = 1'b0;
        @(posedge clk); #1;
        a_rst = 1'b1;
        chk("t4_rst_sync", int'(a_sync), 1);
        chk("t4_rst_sclk", int'(a_sclk), 1);
        chk("t4_rst_din", int'(a_din), 1);
        chk("t4_rst_busy", int'(a_busy), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_no_done_pulses", fd_cnt[0] + ad_cnt[0], 0);
        pulse_a();
        wait_ad(0, 1, 400, "t4_all_done_seen");
        chk("t4_fresh_word", int'(wlog[0][0]), 24'h16A5C3);
        chk("t4_fresh_frames", wn[0], 1);

        // fast instance, start held high across two batches
        b_mask = 2'b11; b_hdr = 16'h3AC5; b_val = 32'h0102_FEDC;
        clr(1);
        b_start = 1'b1;
        wait_ad(1, 2, 400, "t5_two_batches_seen");
        b_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_frames", wn[1], 4);
        chk("t5_word0", int'(wlog[1][0]), 24'hC5FEDC);
        chk("t5_word1", int'(wlog[1][1]), 24'h3A0102);
        chk("t5_word2", int'(wlog[1][2]), 24'hC5FEDC);
        chk("t5_word3", int'(wlog[1][3]), 24'h3A0102);
        chk("t5_sync_low_cycles", lo_last[1], 48);
        chk("t5_sclk_period", fall_per[1], 2);
        chk("t5_gap_high_cycles", gap_last[1], 2);
        chk("t5_reaccept_after_all_done", ba_first[1], 1);
        chk("t5_idle_after", int'(b_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
